// File: rtl/conv_pkg.sv
// Shared constants, bank selects and FSM state type for the CONV host memory block.
package conv_pkg;

  localparam int DW    = 20;
  localparam int AW    = 12;
  localparam int L1_AW = 10;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READY,
    S_WAIT,
    S_DONE
  } state_e;

  function automatic logic csel_valid(input logic [2:0] sel);
    return (sel == CSEL_L0) || (sel == CSEL_L1);
  endfunction

endpackage

// File: rtl/conv_host_mem_if.sv
// Engine-side CONV bus: start handshake, image read port and layer read/write port.
interface conv_host_mem_if;
  import conv_pkg::*;

  logic          ready;
  logic          busy;
  logic [AW-1:0] iaddr;
  logic [DW-1:0] idata;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic [2:0]    csel;

  modport master (
    input  ready, idata, cdata_rd,
    output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

  modport slave (
    output ready, idata, cdata_rd,
    input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

endinterface

// File: rtl/conv_sp_ram.sv
// Simple RAM: one synchronous write port and two asynchronous read ports, contents not reset.
module conv_sp_ram #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 20
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads see the pre-write word on a same-cycle collision.
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/conv_host_mem.sv
// Host end of the CONV accelerator bus: image/L0/L1 memories, start handshake FSM,
// write counters, run timeout and sticky protocol checking.
module conv_host_mem
  import conv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [DW-1:0]    load_data,
  input  logic             start,
  conv_host_mem_if.slave   eng,
  input  logic             dump_sel,
  input  logic [AW-1:0]    dump_addr,
  output logic [DW-1:0]    dump_data,
  output logic             done,
  output logic             timeout,
  output logic             proto_err,
  output logic [AW:0]      l0_wcnt,
  output logic [L1_AW:0]   l1_wcnt
);

  localparam logic [31:0]    TO_LIM = TIMEOUT_CYC;
  localparam logic [AW:0]    L0_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [L1_AW:0] L1_ONE = {{L1_AW{1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             perr_q, perr_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [31:0]      cyc_inc;
  logic [AW:0]      l0_wcnt_q, l0_wcnt_d;
  logic [L1_AW:0]   l1_wcnt_q, l1_wcnt_d;
  logic [DW-1:0]    dump_q, dump_d;

  logic             img_we, l0_we, l1_we;
  logic [DW-1:0]    img_rdata, img_dump_unused;
  logic [DW-1:0]    l0_rdata, l0_dump;
  logic [DW-1:0]    l1_rdata, l1_dump;
  logic [DW-1:0]    cdata_rd;

  assign img_we = load_en && (state_q == S_IDLE);
  assign l0_we  = eng.cwr && (eng.csel == CSEL_L0);
  assign l1_we  = eng.cwr && (eng.csel == CSEL_L1);

  conv_sp_ram #(.ADDR_W(AW), .DATA_W(DW)) u_img (
    .clk     (clk),
    .we      (img_we),
    .waddr   (load_addr),
    .wdata   (load_data),
    .raddr_a (eng.iaddr),
    .rdata_a (img_rdata),
    .raddr_b (dump_addr),
    .rdata_b (img_dump_unused)
  );

  conv_sp_ram #(.ADDR_W(AW), .DATA_W(DW)) u_l0 (
    .clk     (clk),
    .we      (l0_we),
    .waddr   (eng.caddr_wr),
    .wdata   (eng.cdata_wr),
    .raddr_a (eng.caddr_rd),
    .rdata_a (l0_rdata),
    .raddr_b (dump_addr),
    .rdata_b (l0_dump)
  );

  conv_sp_ram #(.ADDR_W(L1_AW), .DATA_W(DW)) u_l1 (
    .clk     (clk),
    .we      (l1_we),
    .waddr   (eng.caddr_wr[L1_AW-1:0]),
    .wdata   (eng.cdata_wr),
    .raddr_a (eng.caddr_rd[L1_AW-1:0]),
    .rdata_a (l1_rdata),
    .raddr_b (dump_addr[L1_AW-1:0]),
    .rdata_b (l1_dump)
  );

  always_comb begin
    cdata_rd = '0;
    if (reset && eng.crd) begin
      case (eng.csel)
        CSEL_L0: cdata_rd = l0_rdata;
        CSEL_L1: cdata_rd = l1_rdata;
        default: cdata_rd = '0;
      endcase
    end
  end

  // Read data is forced low while reset is held so every output reads zero.
  assign eng.idata    = reset ? img_rdata : '0;
  assign eng.cdata_rd = cdata_rd;
  assign eng.ready    = ready_q;

  assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    perr_d    = perr_q;
    cyc_d     = cyc_q;
    l0_wcnt_d = (l0_we && l0_wcnt_q != '1) ? l0_wcnt_q + L0_ONE : l0_wcnt_q;
    l1_wcnt_d = (l1_we && l1_wcnt_q != '1) ? l1_wcnt_q + L1_ONE : l1_wcnt_q;
    dump_d    = dump_sel ? l1_dump : l0_dump;

    if ((load_en && state_q != S_IDLE) ||
        ((eng.cwr || eng.crd) && state_q != S_WAIT) ||
        (eng.cwr && eng.crd) ||
        (eng.cwr && !csel_valid(eng.csel))) begin
      perr_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_READY;
          cyc_d     = '0;
          l0_wcnt_d = '0;
          l1_wcnt_d = '0;
        end
      end
      S_READY: begin
        cyc_d = cyc_inc;
        if (eng.busy) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cyc_d = cyc_inc;
        // Entry required busy=1, so a low busy here is always a falling edge.
        if (cyc_inc >= TO_LIM) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else if (!eng.busy) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_READY);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      perr_q    <= 1'b0;
      cyc_q     <= '0;
      l0_wcnt_q <= '0;
      l1_wcnt_q <= '0;
      dump_q    <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      perr_q    <= perr_d;
      cyc_q     <= cyc_d;
      l0_wcnt_q <= l0_wcnt_d;
      l1_wcnt_q <= l1_wcnt_d;
      dump_q    <= dump_d;
    end
  end

  assign dump_data = dump_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign proto_err = perr_q;
  assign l0_wcnt   = l0_wcnt_q;
  assign l1_wcnt   = l1_wcnt_q;

endmodule

// File: tb/tb_conv_host_mem.sv
// Randomised bench for conv_host_mem: an event-level model of the memories and run
// handshake is compared against the DUT every cycle, plus directed literal checks.
module tb_conv_host_mem;
  import conv_pkg::*;

  localparam int unsigned TO = 50;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          start;
  logic          dump_sel;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          done, timeout, proto_err;
  logic [AW:0]   l0_wcnt;
  logic [L1_AW:0] l1_wcnt;

  conv_host_mem_if eng_if ();

  conv_host_mem #(.TIMEOUT_CYC(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .eng       (eng_if),
    .dump_sel  (dump_sel),
    .dump_addr (dump_addr),
    .dump_data (dump_data),
    .done      (done),
    .timeout   (timeout),
    .proto_err (proto_err),
    .l0_wcnt   (l0_wcnt),
    .l1_wcnt   (l1_wcnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference state: memory images with written-flags and the run as plain flags.
  logic [DW-1:0] img_m [4096];
  bit            img_v [4096];
  logic [DW-1:0] l0_m  [4096];
  bit            l0_v  [4096];
  logic [DW-1:0] l1_m  [1024];
  bit            l1_v  [1024];
  bit            m_ready, m_wait, m_done, m_timeout, m_perr;
  int            m_cyc, m_l0cnt, m_l1cnt;
  logic [DW-1:0] m_dump;
  bit            m_dump_v;

  always @(posedge clk or negedge reset) begin : model
    bit idle;
    if (!reset) begin
      m_ready = 0; m_wait = 0; m_done = 0; m_timeout = 0; m_perr = 0;
      m_cyc = 0; m_l0cnt = 0; m_l1cnt = 0; m_dump = '0; m_dump_v = 1;
    end else begin
      idle = !(m_ready || m_wait || m_done);
      if (load_en && !idle) m_perr = 1;
      if ((eng_if.cwr || eng_if.crd) && !m_wait) m_perr = 1;
      if (eng_if.cwr && eng_if.crd) m_perr = 1;
      if (eng_if.cwr && eng_if.csel != 3'b001 && eng_if.csel != 3'b011) m_perr = 1;
      if (dump_sel) begin
        m_dump = l1_m[dump_addr[9:0]]; m_dump_v = l1_v[dump_addr[9:0]];
      end else begin
        m_dump = l0_m[dump_addr]; m_dump_v = l0_v[dump_addr];
      end
      if (eng_if.cwr && eng_if.csel == 3'b001) begin
        l0_m[eng_if.caddr_wr] = eng_if.cdata_wr; l0_v[eng_if.caddr_wr] = 1;
        if (m_l0cnt < 8191) m_l0cnt++;
      end
      if (eng_if.cwr && eng_if.csel == 3'b011) begin
        l1_m[eng_if.caddr_wr[9:0]] = eng_if.cdata_wr; l1_v[eng_if.caddr_wr[9:0]] = 1;
        if (m_l1cnt < 2047) m_l1cnt++;
      end
      if (load_en && idle) begin
        img_m[load_addr] = load_data; img_v[load_addr] = 1;
      end
      if (m_done) begin
        m_done = 0;
      end else if (idle) begin
        if (start) begin
          m_ready = 1; m_cyc = 0; m_l0cnt = 0; m_l1cnt = 0;
        end
      end else if (m_ready) begin
        m_cyc++;
        if (eng_if.busy) begin m_ready = 0; m_wait = 1; end
      end else begin
        m_cyc++;
        if (m_cyc >= int'(TO)) begin
          m_timeout = 1; m_wait = 0; m_done = 1;
        end else if (!eng_if.busy) begin
          m_wait = 0; m_done = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the reference, sampled mid low-phase.
  always @(negedge clk) begin
    #2;
    check_output("ready", 32'(eng_if.ready), 32'(m_ready));
    check_output("done", 32'(done), 32'(m_done));
    check_output("timeout", 32'(timeout), 32'(m_timeout));
    check_output("proto_err", 32'(proto_err), 32'(m_perr));
    check_output("l0_wcnt", 32'(l0_wcnt), m_l0cnt);
    check_output("l1_wcnt", 32'(l1_wcnt), m_l1cnt);
    if (m_dump_v) check_output("dump_data", 32'(dump_data), 32'(m_dump));
    if (!reset) check_output("idata_rst", 32'(eng_if.idata), 0);
    else if (img_v[eng_if.iaddr]) check_output("idata", 32'(eng_if.idata), 32'(img_m[eng_if.iaddr]));
    if (!reset || !eng_if.crd || (eng_if.csel != 3'b001 && eng_if.csel != 3'b011))
      check_output("cdata_rd_zero", 32'(eng_if.cdata_rd), 0);
    else if (eng_if.csel == 3'b001 && l0_v[eng_if.caddr_rd])
      check_output("cdata_rd_l0", 32'(eng_if.cdata_rd), 32'(l0_m[eng_if.caddr_rd]));
    else if (eng_if.csel == 3'b011 && l1_v[eng_if.caddr_rd[9:0]])
      check_output("cdata_rd_l1", 32'(eng_if.cdata_rd), 32'(l1_m[eng_if.caddr_rd[9:0]]));
  end

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 7))
      0: return 12'h000;
      1: return 12'hFFF;
      2: return 12'h041;
      3: return 12'h3FF;
      4: return 12'hBFF;
      default: return 12'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [AW-1:0] pick_load_addr();
    case ($urandom_range(0, 3))
      0: return 12'h041;
      1: return 12'h3FF;
      2: return 12'hBFF;
      default: return 12'($urandom_range(1, 31));
    endcase
  endfunction

  task automatic apply_stimulus(input bit traffic, input bit dirty);
    @(negedge clk);
    eng_if.iaddr    = pick_addr();
    eng_if.caddr_rd = pick_addr();
    eng_if.caddr_wr = pick_addr();
    eng_if.cdata_wr = 20'($urandom);
    dump_sel        = 1'($urandom_range(0, 1));
    dump_addr       = pick_addr();
    eng_if.cwr = 0; eng_if.crd = 0; eng_if.csel = CSEL_NONE; load_en = 0; start = 0;
    if (traffic && dirty) begin
      eng_if.cwr  = 1'($urandom_range(0, 1));
      eng_if.crd  = 1'($urandom_range(0, 1));
      eng_if.csel = 3'($urandom_range(0, 7));
      load_en     = ($urandom_range(0, 3) == 0);
      load_addr   = pick_load_addr();
      load_data   = 20'($urandom);
    end else if (traffic) begin
      case ($urandom_range(0, 3))
        1: eng_if.cwr = 1;
        2: eng_if.crd = 1;
        default: ;
      endcase
      eng_if.csel = ($urandom_range(0, 1) == 1) ? CSEL_L0 : CSEL_L1;
    end
  endtask

  task automatic idle_load(input int n);
    for (int i = 0; i < n; i++) begin
      apply_stimulus(0, 0);
      load_en   = 1'($urandom_range(0, 1));
      load_addr = pick_load_addr();
      load_data = 20'($urandom);
    end
  endtask

  task automatic run_clean(input int ready_len, input int wait_len);
    apply_stimulus(0, 0);
    start = 1;
    apply_stimulus(0, 0);
    for (int i = 0; i < ready_len; i++) apply_stimulus(0, 0);
    eng_if.busy = 1;
    for (int i = 0; i < wait_len; i++) apply_stimulus(1, 0);
    apply_stimulus(0, 0);
    eng_if.busy = 0;
    repeat (2) apply_stimulus(0, 0);
  endtask

  initial begin : watchdog
    #200000;
    bad++;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : main
    int n;
    load_en = 0; load_addr = '0; load_data = '0; start = 0; dump_sel = 0; dump_addr = '0;
    eng_if.busy = 0; eng_if.iaddr = '0; eng_if.cwr = 0; eng_if.caddr_wr = '0;
    eng_if.cdata_wr = '0; eng_if.crd = 0; eng_if.caddr_rd = '0; eng_if.csel = CSEL_NONE;
    #1 reset = 0;
    repeat (2) @(negedge clk);
    #3;
    check_output("rst_ready", 32'(eng_if.ready), 0);
    check_output("rst_done", 32'(done), 0);
    check_output("rst_dump", 32'(dump_data), 0);
    check_output("rst_perr", 32'(proto_err), 0);

    @(negedge clk); reset = 1;
    @(negedge clk); load_en = 1; load_addr = 12'h000; load_data = 20'h0A89E;
    @(negedge clk); load_addr = 12'hFFF; load_data = 20'hFFFFF;
    for (int a = 1; a < 32; a++) begin
      @(negedge clk); load_addr = 12'(a); load_data = 20'($urandom);
    end
    @(negedge clk); load_en = 0; eng_if.iaddr = 12'h000;
    #3 check_output("idata_0", 32'(eng_if.idata), 32'h0A89E);
    @(negedge clk); eng_if.iaddr = 12'hFFF;
    #3 check_output("idata_4095", 32'(eng_if.idata), 32'hFFFFF);

    // Directed run: handshake, L0/L1 writes, readback and dump.
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    #3 check_output("ready_rise", 32'(eng_if.ready), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #3 check_output("ready_hold", 32'(eng_if.ready), 1);
    end
    @(negedge clk); eng_if.busy = 1;
    @(negedge clk); eng_if.cwr = 1; eng_if.csel = CSEL_L0; eng_if.caddr_wr = 12'h041; eng_if.cdata_wr = 20'h12345;
    #3 check_output("ready_drop", 32'(eng_if.ready), 0);
    @(negedge clk); eng_if.csel = CSEL_L1; eng_if.caddr_wr = 12'h3FF; eng_if.cdata_wr = 20'h54321;
    @(negedge clk); eng_if.cwr = 0; eng_if.crd = 1; eng_if.csel = CSEL_L0; eng_if.caddr_rd = 12'h041;
    dump_sel = 0; dump_addr = 12'h041;
    #3 check_output("cdata_l0_041", 32'(eng_if.cdata_rd), 32'h12345);
    check_output("l0_wcnt_1", 32'(l0_wcnt), 1);
    check_output("l1_wcnt_1", 32'(l1_wcnt), 1);
    @(negedge clk); eng_if.crd = 0; dump_sel = 1; dump_addr = 12'h3FF;
    #3 check_output("dump_l0_041", 32'(dump_data), 32'h12345);
    @(negedge clk);
    #3 check_output("dump_l1_3ff", 32'(dump_data), 32'h54321);
    for (int i = 0; i < 10; i++) apply_stimulus(1, 0);
    apply_stimulus(0, 0); eng_if.busy = 0;
    #3 check_output("done_not_yet", 32'(done), 0);
    @(negedge clk);
    #3 check_output("done_pulse", 32'(done), 1);
    @(negedge clk);
    #3 check_output("done_clear", 32'(done), 0);

    for (int r = 0; r < 6; r++) begin
      idle_load($urandom_range(1, 4));
      run_clean($urandom_range(0, 4), $urandom_range(3, 25));
    end
    #3 check_output("clean_perr", 32'(proto_err), 0);

    // Timeout: busy never falls.
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; eng_if.busy = 1;
    n = 0;
    while (n <= 100) begin
      #3;
      if (done) break;
      n++;
      @(negedge clk);
    end
    check_output("timeout_cycle", n, 50);
    check_output("timeout_flag", 32'(timeout), 1);
    @(negedge clk); eng_if.busy = 0;
    repeat (2) @(negedge clk);

    // Bad bank select, then reset in the middle of S_WAIT.
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); eng_if.busy = 1;
    @(negedge clk); eng_if.cwr = 1; eng_if.csel = CSEL_L0; eng_if.caddr_wr = 12'h041; eng_if.cdata_wr = 20'h0BEEF;
    @(negedge clk); eng_if.csel = 3'b010; eng_if.cdata_wr = 20'hFFFFF;
    @(negedge clk); eng_if.cwr = 0; eng_if.crd = 1; eng_if.csel = CSEL_L0; eng_if.caddr_rd = 12'h041;
    #3 check_output("perr_bad_csel", 32'(proto_err), 1);
    check_output("bad_csel_no_write", 32'(eng_if.cdata_rd), 32'h0BEEF);
    @(negedge clk); eng_if.crd = 0; eng_if.csel = CSEL_NONE; reset = 0;
    #3 check_output("midrst_ready", 32'(eng_if.ready), 0);
    check_output("midrst_done", 32'(done), 0);
    check_output("midrst_perr", 32'(proto_err), 0);
    @(negedge clk); reset = 1; eng_if.busy = 0; eng_if.iaddr = 12'h000; dump_sel = 0; dump_addr = 12'h041;
    #3 check_output("retain_img0", 32'(eng_if.idata), 32'h0A89E);
    @(negedge clk);
    #3 check_output("retain_l0_041", 32'(dump_data), 32'h0BEEF);

    // Simultaneous read and write, then unconstrained traffic.
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); eng_if.busy = 1;
    @(negedge clk); eng_if.cwr = 1; eng_if.crd = 1; eng_if.csel = CSEL_L1;
    eng_if.caddr_wr = 12'h010; eng_if.caddr_rd = 12'h010; eng_if.cdata_wr = 20'h0F0F0;
    @(negedge clk); eng_if.cwr = 0; eng_if.crd = 0;
    #3 check_output("perr_wr_rd", 32'(proto_err), 1);
    for (int i = 0; i < 20; i++) apply_stimulus(1, 1);
    apply_stimulus(0, 0); eng_if.busy = 0;
    repeat (3) apply_stimulus(0, 0);
    idle_load(3);
    run_clean(2, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
